// File: rtl/aer_pkg.sv
// aer_pkg: state encoding and AER word constants shared by the
// input scheduler and its wait counter.
package aer_pkg;
  localparam int unsigned AER_W = 16;
  localparam logic [AER_W-1:0] STEP_MARK = 16'hFFFF;
  localparam logic [AER_W-1:0] FRAME_MARK = '0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_ISSUE,
    S_LAUNCH,
    S_WAITREQ,
    S_STEP_END,
    S_DONE
  } sched_state_e;
endpackage

// File: rtl/aer_sched_wait_cnt.sv
// aer_sched_wait_cnt: loadable down-counter that saturates at zero,
// used for the launch holdoff and the optional request watchdog.
module aer_sched_wait_cnt #(
  parameter int unsigned W = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic         en_i,
  input  logic [W-1:0] load_val_i,
  output logic         zero_o
);
  logic [W-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/aer_input_scheduler.sv
// aer_input_scheduler: feeds RAM events to conv layer 1 one at a time.
// Optional request watchdog enabled by AER_SCHED_TIMEOUT_EN.
module aer_input_scheduler
  import aer_pkg::*;
#(
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned LAUNCH_WAIT = 3,
  parameter int unsigned TMO_CYC     = 4096
) (
  input  logic              work_clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic              ev_rd_en,
  output logic [ADDR_W-1:0] ev_rd_addr,
  input  logic [AER_W-1:0]  ev_rd_data,
  output logic [AER_W-1:0]  conv_aer_o,
  input  logic              conv_req_i,
  output logic              busy,
  output logic              step_done,
  output logic              frame_done,
  output logic [7:0]        step_cnt,
  output logic              dup_skip,
  output logic              ovf,
  output logic              tmo_err
);
  localparam int unsigned LW = $clog2(LAUNCH_WAIT) + 1;

  sched_state_e      state_q;
  logic              rd_en_q;
  logic [ADDR_W-1:0] addr_q;
  logic [AER_W-1:0]  aer_q;
  logic [AER_W-1:0]  last_ev_q;
  logic [7:0]        step_cnt_q;
  logic              busy_q;
  logic              step_done_q;
  logic              frame_done_q;
  logic              dup_skip_q;
  logic              ovf_q;
  logic              tmo_err_q;
  logic              wrap_q;

  logic at_end;
  logic is_frame;
  logic is_step;
  logic is_dup;
  logic l_zero;
  logic tmo_hit;

  assign at_end   = &addr_q;
  assign is_frame = (ev_rd_data == FRAME_MARK);
  assign is_step  = (ev_rd_data == STEP_MARK);
  assign is_dup   = (ev_rd_data == last_ev_q) && !is_frame && !is_step;

  aer_sched_wait_cnt #(.W(LW)) u_launch (
    .clk_i      (work_clk),
    .rst_i      (rst_n),
    .load_i     (state_q != S_LAUNCH),
    .en_i       (state_q == S_LAUNCH),
    .load_val_i (LW'(LAUNCH_WAIT - 1)),
    .zero_o     (l_zero)
  );

`ifdef AER_SCHED_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TMO_CYC) + 1;
  logic tmo_run;
  logic tmo_zero;

  assign tmo_run = (state_q == S_WAITREQ) || (state_q == S_STEP_END);

  aer_sched_wait_cnt #(.W(TW)) u_tmo (
    .clk_i      (work_clk),
    .rst_i      (rst_n),
    .load_i     (!tmo_run),
    .en_i       (tmo_run),
    .load_val_i (TW'(TMO_CYC - 1)),
    .zero_o     (tmo_zero)
  );

  assign tmo_hit = tmo_run & tmo_zero & ~conv_req_i;
`else
  logic unused_tmo;
  assign unused_tmo = (TMO_CYC != 0);
  assign tmo_hit    = 1'b0;
`endif

  always_ff @(posedge work_clk) begin
    if (rst_n) begin
      state_q      <= S_IDLE;
      rd_en_q      <= 1'b0;
      addr_q       <= '0;
      aer_q        <= '0;
      last_ev_q    <= '0;
      step_cnt_q   <= '0;
      busy_q       <= 1'b0;
      step_done_q  <= 1'b0;
      frame_done_q <= 1'b0;
      dup_skip_q   <= 1'b0;
      ovf_q        <= 1'b0;
      tmo_err_q    <= 1'b0;
      wrap_q       <= 1'b0;
    end else if (abort) begin
      state_q      <= S_IDLE;
      rd_en_q      <= 1'b0;
      aer_q        <= '0;
      busy_q       <= 1'b0;
      step_done_q  <= 1'b0;
      frame_done_q <= 1'b0;
      dup_skip_q   <= 1'b0;
    end else begin
      rd_en_q      <= 1'b0;
      aer_q        <= '0;
      step_done_q  <= 1'b0;
      frame_done_q <= 1'b0;
      dup_skip_q   <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q    <= S_FETCH;
            rd_en_q    <= 1'b1;
            busy_q     <= 1'b1;
            addr_q     <= '0;
            step_cnt_q <= '0;
            ovf_q      <= 1'b0;
            tmo_err_q  <= 1'b0;
            wrap_q     <= 1'b0;
          end
        end
        S_FETCH: state_q <= S_DECODE;
        S_DECODE: begin
          unique case (1'b1)
            is_frame: begin
              state_q      <= S_DONE;
              frame_done_q <= 1'b1;
            end
            is_step: state_q <= S_STEP_END;
            is_dup: begin
              dup_skip_q <= 1'b1;
              if (at_end) begin
                ovf_q        <= 1'b1;
                state_q      <= S_DONE;
                frame_done_q <= 1'b1;
              end else begin
                addr_q  <= addr_q + 1'b1;
                state_q <= S_FETCH;
                rd_en_q <= 1'b1;
              end
            end
            default: begin
              last_ev_q <= ev_rd_data;
              aer_q     <= ev_rd_data;
              state_q   <= S_ISSUE;
            end
          endcase
        end
        S_ISSUE: begin
          // remember the wrap so the last-address event still gets its wait
          wrap_q  <= at_end;
          addr_q  <= addr_q + 1'b1;
          state_q <= S_LAUNCH;
        end
        S_LAUNCH: begin
          if (l_zero) state_q <= S_WAITREQ;
        end
        S_WAITREQ: begin
          if (conv_req_i) begin
            if (wrap_q) begin
              ovf_q        <= 1'b1;
              state_q      <= S_DONE;
              frame_done_q <= 1'b1;
            end else begin
              state_q <= S_FETCH;
              rd_en_q <= 1'b1;
            end
          end else if (tmo_hit) begin
            tmo_err_q    <= 1'b1;
            frame_done_q <= 1'b1;
            busy_q       <= 1'b0;
            state_q      <= S_IDLE;
          end
        end
        S_STEP_END: begin
          if (conv_req_i) begin
            step_done_q <= 1'b1;
            step_cnt_q  <= step_cnt_q + 8'd1;
            if (at_end) begin
              ovf_q        <= 1'b1;
              state_q      <= S_DONE;
              frame_done_q <= 1'b1;
            end else begin
              addr_q  <= addr_q + 1'b1;
              state_q <= S_FETCH;
              rd_en_q <= 1'b1;
            end
          end else if (tmo_hit) begin
            tmo_err_q    <= 1'b1;
            frame_done_q <= 1'b1;
            busy_q       <= 1'b0;
            state_q      <= S_IDLE;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ev_rd_en   = rd_en_q;
  assign ev_rd_addr = addr_q;
  assign conv_aer_o = aer_q;
  assign busy       = busy_q;
  assign step_done  = step_done_q;
  assign frame_done = frame_done_q;
  assign step_cnt   = step_cnt_q;
  assign dup_skip   = dup_skip_q;
  assign ovf        = ovf_q;
  assign tmo_err    = tmo_err_q;
endmodule

// File: tb/tb_aer_input_scheduler.sv
// tb_aer_input_scheduler: directed scenarios for the AER input scheduler.
// Cycle n of a frame is the cycle with cyc == base + n (start at cycle 0).
module tb_aer_input_scheduler;
  import aer_pkg::*;

  localparam int unsigned AW = 4;
`ifdef AER_SCHED_TIMEOUT_EN
  localparam int BP_LEN = 10;
`else
  localparam int BP_LEN = 20;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          ev_rd_en;
  logic [AW-1:0] ev_rd_addr;
  logic [15:0]   ev_rd_data = '0;
  logic [15:0]   conv_aer_o;
  logic          conv_req_i = 1'b1;
  logic          busy, step_done, frame_done, dup_skip, ovf, tmo_err;
  logic [7:0]    step_cnt;

  aer_input_scheduler #(
    .ADDR_W(AW), .LAUNCH_WAIT(3), .TMO_CYC(16)
  ) dut (
    .work_clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .ev_rd_en(ev_rd_en), .ev_rd_addr(ev_rd_addr), .ev_rd_data(ev_rd_data),
    .conv_aer_o(conv_aer_o), .conv_req_i(conv_req_i), .busy(busy),
    .step_done(step_done), .frame_done(frame_done), .step_cnt(step_cnt),
    .dup_skip(dup_skip), .ovf(ovf), .tmo_err(tmo_err)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [16];
  always @(posedge clk) if (ev_rd_en) ev_rd_data <= mem[ev_rd_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          ev_cyc[$];
  logic [15:0] ev_val[$];
  int n_dup, n_step, n_frame, dup_cyc, fd_cyc;
  int checks = 0, failures = 0;

  always @(negedge clk) begin
    if (conv_aer_o != '0) begin
      ev_cyc.push_back(cyc);
      ev_val.push_back(conv_aer_o);
    end
    if (dup_skip) begin n_dup++; dup_cyc = cyc; end
    if (step_done) n_step++;
    if (frame_done) begin n_frame++; fd_cyc = cyc; end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic to_cycle(input int b, input int n);
    while (cyc < b + n) tick(1);
  endtask

  task automatic clr_mon();
    ev_cyc.delete(); ev_val.delete();
    n_dup = 0; n_step = 0; n_frame = 0; dup_cyc = -1; fd_cyc = -1;
  endtask

  task automatic clr_mem();
    foreach (mem[i]) mem[i] = 16'h0000;
  endtask

  task automatic do_start(output int b);
    tick(1);
    b = cyc;
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    tick(3);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (ev_rd_en !== 1'b0) begin failures++; $display("FAIL reset_rd_en: got %b want 0", ev_rd_en); end
    checks++; if (ev_rd_addr !== '0) begin failures++; $display("FAIL reset_addr: got %h want 0", ev_rd_addr); end
    checks++; if (conv_aer_o !== 16'h0) begin failures++; $display("FAIL reset_aer: got %h want 0", conv_aer_o); end
    checks++; if ({step_done, frame_done, dup_skip} !== 3'b000) begin failures++; $display("FAIL reset_pulses: got %b want 000", {step_done, frame_done, dup_skip}); end
    checks++; if (step_cnt !== 8'd0) begin failures++; $display("FAIL reset_step_cnt: got %0d want 0", step_cnt); end
    checks++; if ({ovf, tmo_err} !== 2'b00) begin failures++; $display("FAIL reset_sticky: got %b want 00", {ovf, tmo_err}); end
    rst_n = 1'b0;
    tick(2);
  endtask

  task automatic test_single();
    int b;
    clr_mem(); mem[0] = 16'h0123; conv_req_i = 1'b1; clr_mon();
    do_start(b);
    checks++; if (ev_rd_en !== 1'b1) begin failures++; $display("FAIL single_rd_en_c1: got %b want 1", ev_rd_en); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_busy_c1: got %b want 1", busy); end
    to_cycle(b, 20);
    checks++;
    if (ev_cyc.size() != 1) begin
      failures++; $display("FAIL single_count: got %0d want 1", ev_cyc.size());
    end else begin
      checks++; if (ev_cyc[0] - b != 3) begin failures++; $display("FAIL single_issue_cyc: got %0d want 3", ev_cyc[0] - b); end
      checks++; if (ev_val[0] !== 16'h0123) begin failures++; $display("FAIL single_issue_val: got %h want 0123", ev_val[0]); end
    end
    checks++; if (n_frame != 1 || fd_cyc - b != 10) begin failures++; $display("FAIL single_frame_done: got n=%0d cyc=%0d want n=1 cyc=10", n_frame, fd_cyc - b); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_busy_end: got %b want 0", busy); end
  endtask

  task automatic test_back_to_back();
    int b;
    int exp_c[3];
    logic [15:0] exp_v[3];
    exp_c = '{3, 10, 17};
    exp_v = '{16'h000A, 16'h000B, 16'h000C};
    clr_mem(); mem[0] = 16'h000A; mem[1] = 16'h000B; mem[2] = 16'h000C;
    conv_req_i = 1'b1; clr_mon();
    do_start(b);
    to_cycle(b, 5);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    to_cycle(b, 40);
    checks++;
    if (ev_cyc.size() != 3) begin
      failures++; $display("FAIL b2b_count: got %0d want 3", ev_cyc.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (ev_cyc[i] - b != exp_c[i] || ev_val[i] !== exp_v[i]) begin
          failures++;
          $display("FAIL b2b_ev%0d: got cyc=%0d val=%h want cyc=%0d val=%h", i, ev_cyc[i] - b, ev_val[i], exp_c[i], exp_v[i]);
        end
      end
    end
    checks++; if (n_frame != 1 || fd_cyc - b != 24) begin failures++; $display("FAIL b2b_frame_done: got n=%0d cyc=%0d want n=1 cyc=24", n_frame, fd_cyc - b); end
  endtask

  task automatic test_backpressure();
    int b;
    clr_mem(); mem[0] = 16'h0021; mem[1] = 16'h0022;
    conv_req_i = 1'b1; clr_mon();
    do_start(b);
    to_cycle(b, 4);
    conv_req_i = 1'b0;
    to_cycle(b, 4 + BP_LEN);
    conv_req_i = 1'b1;
    to_cycle(b, 4 + BP_LEN + 30);
    checks++;
    if (ev_cyc.size() != 2) begin
      failures++; $display("FAIL bp_count: got %0d want 2", ev_cyc.size());
    end else begin
      checks++; if (ev_cyc[0] - b != 3) begin failures++; $display("FAIL bp_first_cyc: got %0d want 3", ev_cyc[0] - b); end
      // last low cycle is 3+BP_LEN; FETCH, DECODE, ISSUE follow
      checks++; if (ev_cyc[1] - b != 7 + BP_LEN || ev_val[1] !== 16'h0022) begin failures++; $display("FAIL bp_second: got cyc=%0d val=%h want cyc=%0d val=0022", ev_cyc[1] - b, ev_val[1], 7 + BP_LEN); end
    end
  endtask

  task automatic test_dup();
    int b;
    clr_mem(); mem[0] = 16'h0050; mem[1] = 16'h0050; mem[2] = 16'h0051;
    conv_req_i = 1'b1; clr_mon();
    do_start(b);
    to_cycle(b, 30);
    checks++; if (n_dup != 1 || dup_cyc - b != 10) begin failures++; $display("FAIL dup_pulse: got n=%0d cyc=%0d want n=1 cyc=10", n_dup, dup_cyc - b); end
    checks++;
    if (ev_cyc.size() != 2) begin
      failures++; $display("FAIL dup_count: got %0d want 2", ev_cyc.size());
    end else begin
      checks++; if (ev_val[0] !== 16'h0050 || ev_val[1] !== 16'h0051) begin failures++; $display("FAIL dup_vals: got %h %h want 0050 0051", ev_val[0], ev_val[1]); end
      checks++; if (ev_cyc[1] - b != 12) begin failures++; $display("FAIL dup_second_cyc: got %0d want 12", ev_cyc[1] - b); end
    end
  endtask

  task automatic test_steps();
    int b;
    clr_mem();
    mem[0] = 16'h0010; mem[1] = 16'hFFFF; mem[2] = 16'h0010;
    mem[3] = 16'h0011; mem[4] = 16'hFFFF;
    conv_req_i = 1'b1; clr_mon();
    do_start(b);
    to_cycle(b, 40);
    checks++; if (n_step != 2) begin failures++; $display("FAIL steps_pulses: got %0d want 2", n_step); end
    checks++; if (step_cnt !== 8'd2) begin failures++; $display("FAIL steps_cnt: got %0d want 2", step_cnt); end
    checks++; if (n_dup != 1) begin failures++; $display("FAIL steps_dup: got %0d want 1", n_dup); end
    checks++;
    if (ev_cyc.size() != 2) begin
      failures++; $display("FAIL steps_count: got %0d want 2", ev_cyc.size());
    end else begin
      checks++; if (ev_val[1] !== 16'h0011 || ev_cyc[1] - b != 15) begin failures++; $display("FAIL steps_second: got cyc=%0d val=%h want cyc=15 val=0011", ev_cyc[1] - b, ev_val[1]); end
    end
    checks++; if (n_frame != 1 || fd_cyc - b != 25) begin failures++; $display("FAIL steps_frame_done: got n=%0d cyc=%0d want n=1 cyc=25", n_frame, fd_cyc - b); end
  endtask

  task automatic test_abort();
    int b;
    clr_mem(); mem[0] = 16'h0033; mem[1] = 16'h0034;
    conv_req_i = 1'b1; clr_mon();
    do_start(b);
    to_cycle(b, 4);
    conv_req_i = 1'b0;
    to_cycle(b, 10);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    checks++; if (busy !== 1'b0 || ev_rd_en !== 1'b0 || conv_aer_o !== 16'h0) begin failures++; $display("FAIL abort_idle: got busy=%b rd_en=%b aer=%h want 0 0 0000", busy, ev_rd_en, conv_aer_o); end
    conv_req_i = 1'b1;
    to_cycle(b, 25);
    checks++; if (n_frame != 0) begin failures++; $display("FAIL abort_no_frame_done: got %0d want 0", n_frame); end
    checks++; if (ev_cyc.size() != 1) begin failures++; $display("FAIL abort_events: got %0d want 1", ev_cyc.size()); end
    start = 1'b1; abort = 1'b1;
    tick(1);
    start = 1'b0; abort = 1'b0;
    tick(3);
    checks++; if (busy !== 1'b0 || n_frame != 0) begin failures++; $display("FAIL abort_priority: got busy=%b frames=%0d want 0 0", busy, n_frame); end
  endtask

  task automatic test_ovf();
    int b;
    clr_mem();
    for (int i = 0; i < 16; i++) mem[i] = 16'h0100 + 16'(i);
    conv_req_i = 1'b1; clr_mon();
    do_start(b);
    to_cycle(b, 200);
    checks++; if (ovf !== 1'b1) begin failures++; $display("FAIL ovf_set: got %b want 1", ovf); end
    checks++; if (n_frame != 1 || fd_cyc - b != 113) begin failures++; $display("FAIL ovf_frame_done: got n=%0d cyc=%0d want n=1 cyc=113", n_frame, fd_cyc - b); end
    checks++;
    if (ev_cyc.size() != 16) begin
      failures++; $display("FAIL ovf_count: got %0d want 16", ev_cyc.size());
    end else begin
      checks++; if (ev_val[15] !== 16'h010F || ev_cyc[15] - b != 108) begin failures++; $display("FAIL ovf_last_ev: got cyc=%0d val=%h want cyc=108 val=010F", ev_cyc[15] - b, ev_val[15]); end
    end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ovf_busy: got %b want 0", busy); end
    clr_mem(); mem[0] = 16'h0200; clr_mon();
    do_start(b);
    checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL ovf_clear_on_start: got %b want 0", ovf); end
    to_cycle(b, 20);
  endtask

  task automatic test_reset_last_ev();
    int b;
    clr_mem(); mem[0] = 16'h0077;
    conv_req_i = 1'b1; clr_mon();
    do_start(b);
    to_cycle(b, 20);
    clr_mon();
    do_start(b);
    to_cycle(b, 20);
    checks++; if (n_dup != 1 || ev_cyc.size() != 0) begin failures++; $display("FAIL persist_dup: got dup=%0d ev=%0d want 1 0", n_dup, ev_cyc.size()); end
    clr_mon();
    do_start(b);
    rst_n = 1'b1;
    tick(2);
    rst_n = 1'b0;
    checks++; if (busy !== 1'b0 || step_cnt !== 8'd0) begin failures++; $display("FAIL midreset_idle: got busy=%b cnt=%0d want 0 0", busy, step_cnt); end
    tick(3);
    clr_mon();
    do_start(b);
    to_cycle(b, 20);
    checks++; if (ev_cyc.size() != 1 || n_dup != 0) begin failures++; $display("FAIL reset_clears_last: got ev=%0d dup=%0d want 1 0", ev_cyc.size(), n_dup); end
  endtask

  task automatic test_timeout();
    int b;
    clr_mem(); mem[0] = 16'h0044;
    conv_req_i = 1'b1; clr_mon();
    do_start(b);
    to_cycle(b, 4);
    conv_req_i = 1'b0;
`ifdef AER_SCHED_TIMEOUT_EN
    to_cycle(b, 22);
    checks++; if (tmo_err !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL tmo_early: got tmo=%b busy=%b want 0 1", tmo_err, busy); end
    to_cycle(b, 23);
    checks++; if (tmo_err !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b1) begin failures++; $display("FAIL tmo_hit: got tmo=%b busy=%b fd=%b want 1 0 1", tmo_err, busy, frame_done); end
    to_cycle(b, 30);
    checks++; if (tmo_err !== 1'b1 || n_frame != 1) begin failures++; $display("FAIL tmo_sticky: got tmo=%b frames=%0d want 1 1", tmo_err, n_frame); end
    conv_req_i = 1'b1;
    do_start(b);
    checks++; if (tmo_err !== 1'b0) begin failures++; $display("FAIL tmo_clear: got %b want 0", tmo_err); end
    to_cycle(b, 20);
`else
    to_cycle(b, 60);
    checks++; if (busy !== 1'b1 || tmo_err !== 1'b0 || n_frame != 0) begin failures++; $display("FAIL no_tmo_wait: got busy=%b tmo=%b frames=%0d want 1 0 0", busy, tmo_err, n_frame); end
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    conv_req_i = 1'b1;
    tick(2);
`endif
  endtask

  initial begin
    clr_mem();
    clr_mon();
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_dup();
    test_steps();
    test_abort();
    test_ovf();
    test_reset_last_ev();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
